serial_sum_collector: RTL and testbench

- Downstream stage of the 4-bit serial adder.
- Consumes the LSB-first sum bit stream and the final carry from the bit-serial full adder, and reassembles them into a parallel word.
- Presents the word on a valid/ready output port with a one-word holding register.
- Flags stream framing errors and dropped words, since the serial adder runs free and cannot be stalled.

---
 rtl/serial_sum_collector.sv | 142 ++++++++++++++
 tb/tb_serial_sum_collector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_sum_collector.sv
// serial_sum_collector
//   Downstream stage of the bit-serial adder. Collects the LSB-first sum bit
//   stream plus the final carry into a parallel word. The word is presented on
//   a valid/ready port backed by a one-word holding register. The serial side
//   cannot be stalled, so a completed word that finds the holder occupied is
//   dropped and flagged. A ser_first pulse arriving mid-word is also flagged.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   ser_bit    in   serial sum bit, LSB first
//   ser_valid  in   qualifies ser_bit / ser_first / ser_carry
//   ser_first  in   this bit is bit 0 of a new word
//   ser_carry  in   adder carry-out, sampled with the word's last bit
//   out_sum    out  assembled sum word
//   out_cout   out  carry-out of the word
//   out_zero   out  out_sum == 0
//   out_valid  out  output word available
//   out_ready  in   consumer accepts (transfer on out_valid && out_ready)
//   overrun    out  sticky: a completed word was dropped
//   frame_err  out  sticky: ser_first arrived mid-word
//   err_clr    in   clears overrun and frame_err (a same-cycle event wins)
module serial_sum_collector #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_bit,
  input  logic             ser_valid,
  input  logic             ser_first,
  input  logic             ser_carry,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             frame_err,
  input  logic             err_clr
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    SYNC    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] shreg, shifted;
  logic [CNT_W-1:0] pos;
  logic             accept, complete, frame_evt, load, drop;

  // ---------------------------------------------------------------------------
  // Collector next-state / datapath decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_next = state;
    cnt_next   = cnt;
    shifted    = shreg >> 1;
    shifted[WIDTH-1] = ser_bit;

    // In SYNC only a ser_first bit is taken; in COLLECT every valid bit is.
    accept    = ser_valid && (ser_first || (state == COLLECT));
    frame_evt = ser_valid && ser_first && (state == COLLECT);

    // A ser_first bit always sits at position 0. A mid-word ser_first
    // therefore abandons the partial word by restarting the count. The stale
    // shreg bits are shifted out before the word can complete.
    pos      = ser_first ? '0 : cnt;
    complete = accept && (pos == LAST);

    if (complete) begin
      state_next = SYNC;
      cnt_next   = '0;
    end else if (accept) begin
      state_next = COLLECT;
      cnt_next   = pos + CNT_W'(1);
    end

    // The holder accepts a new word when empty, or when it drains this cycle.
    load = complete && (!out_valid || out_ready);
    drop = complete && out_valid && !out_ready;
  end

  // ---------------------------------------------------------------------------
  // State, counter, shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    if (rst) begin
      state <= SYNC;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) shreg <= shifted;
    end
  end

  // ---------------------------------------------------------------------------
  // Output holding register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_zero  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_sum   <= shifted;
      out_cout  <= ser_carry;
      out_zero  <= (shifted == '0);
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: an event in the clearing cycle keeps the flag set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop)         overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;

      if (frame_evt)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_sum_collector.sv
// Directed self-checking bench for serial_sum_collector (WIDTH = 4).
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, which is well away from the next active edge.
module tb_serial_sum_collector;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ser_bit = 1'b0;
  logic             ser_valid = 1'b0;
  logic             ser_first = 1'b0;
  logic             ser_carry = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_zero;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             overrun;
  logic             frame_err;
  logic             err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  serial_sum_collector #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .ser_first (ser_first),
    .ser_carry (ser_carry),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_zero  (out_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // One valid serial bit for exactly one edge. Back-to-back calls leave no gap.
  task automatic send_bit(input logic b, input logic first, input logic carry);
    ser_bit   = b;
    ser_first = first;
    ser_carry = carry;
    ser_valid = 1'b1;
    idle();
    ser_valid = 1'b0;
    ser_first = 1'b0;
    ser_carry = 1'b0;
  endtask

  // Whole word, LSB first. The optional one-cycle gaps go between bits only.
  task automatic send_word(input logic [WIDTH-1:0] w, input logic carry, input bit gaps);
    for (int i = 0; i < WIDTH; i++) begin
      send_bit(w[i], i == 0, (i == WIDTH - 1) ? carry : 1'b0);
      if (gaps && i < WIDTH - 1) idle();
    end
  endtask

  initial begin
    // Reset values
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    check("rst_sum",   out_sum,   0);
    check("rst_cout",  out_cout,  0);
    check("rst_zero",  out_zero,  0);
    check("rst_valid", out_valid, 0);
    check("rst_ovr",   overrun,   0);
    check("rst_ferr",  frame_err, 0);
    check("rst_cnt",   dut.cnt,   0);

    // A bit without ser_first in SYNC is discarded
    send_bit(1'b1, 1'b0, 1'b0);
    check("nofirst_valid", out_valid, 0);
    check("nofirst_cnt",   dut.cnt,   0);

    // Basic word: bits 1,0,1,1 -> 4'hD, carry 1
    out_ready = 1'b1;
    send_word(4'hD, 1'b1, 1'b0);
    check("basic_valid", out_valid, 1);
    check("basic_sum",   out_sum,   4'hD);
    check("basic_cout",  out_cout,  1);
    check("basic_zero",  out_zero,  0);
    idle();
    check("basic_drain", out_valid, 0);

    // Gaps between bits, zero word
    send_word(4'h0, 1'b0, 1'b1);
    check("zero_valid", out_valid, 1);
    check("zero_sum",   out_sum,   0);
    check("zero_zero",  out_zero,  1);
    check("zero_cout",  out_cout,  0);
    idle();
    check("zero_drain", out_valid, 0);

    // Backpressure overrun: 4'h3 held, 4'hA dropped
    out_ready = 1'b0;
    send_word(4'h3, 1'b0, 1'b0);
    check("ovr_first_valid", out_valid, 1);
    check("ovr_first_sum",   out_sum,   4'h3);
    check("ovr_first_flag",  overrun,   0);
    send_word(4'hA, 1'b1, 1'b0);
    check("ovr_hold_sum",  out_sum,   4'h3);
    check("ovr_hold_cout", out_cout,  0);
    check("ovr_flag",      overrun,   1);
    check("ovr_valid",     out_valid, 1);
    out_ready = 1'b1;
    idle();
    check("ovr_drain",  out_valid, 0);
    check("ovr_sticky", overrun,   1);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    check("ovr_clr", overrun, 0);

    // Simultaneous drain and refill: 4'h5 held, 4'h9 arrives as it drains
    out_ready = 1'b0;
    send_word(4'h5, 1'b0, 1'b0);
    check("dr_hold_sum", out_sum, 4'h5);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    check("dr_still_sum", out_sum, 4'h5);
    out_ready = 1'b1;
    send_bit(1'b1, 1'b0, 1'b0);
    check("dr_refill_sum",   out_sum,   4'h9);
    check("dr_refill_valid", out_valid, 1);
    check("dr_refill_ovr",   overrun,   0);
    idle();
    check("dr_drain", out_valid, 0);

    // ser_first on the 3rd bit: frame_err, restart at that bit (1,1,0,0 -> 3)
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    check("fr_flag",  frame_err, 1);
    check("fr_valid", out_valid, 0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b1);
    check("fr_sum",   out_sum,   4'h3);
    check("fr_cout",  out_cout,  1);
    check("fr_valid2", out_valid, 1);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    check("fr_clr",   frame_err, 0);
    check("fr_drain", out_valid, 0);

    // A framing event in the same cycle as err_clr leaves the flag set
    send_bit(1'b0, 1'b1, 1'b0);
    err_clr = 1'b1;
    send_bit(1'b0, 1'b1, 1'b0);
    err_clr = 1'b0;
    check("fr_clr_race", frame_err, 1);

    // Reset mid-word discards the partial word
    send_bit(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("mrst_cnt",   dut.cnt,   0);
    check("mrst_valid", out_valid, 0);
    check("mrst_ferr",  frame_err, 0);
    idle();
    check("mrst_novalid", out_valid, 0);
    send_word(4'h6, 1'b1, 1'b0);
    check("mrst_sum",   out_sum,   4'h6);
    check("mrst_cout",  out_cout,  1);
    check("mrst_zero",  out_zero,  0);
    check("mrst_valid2", out_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
